ps2_frame_rx: RTL and testbench
===============================

# ps2_frame_rx

Validating PS/2 frame receiver for the keyboard datapath. Sits between `keyboard_negedge_detector` and `hex_display`, consuming the per-falling-edge enable and the PS/2 data line. Assembles and checks 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop. Accepted bytes are published with a one-cycle strobe and shifted into a 24-bit scan-code history that drives the six-digit hex display directly.

## Interface
- `TIMEOUT_CYCLES`, default 50000: clk cycles allowed between consecutive PS/2 falling edges inside a frame (1 ms at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `i_sclr`  in  1  reset; asynchronous, active-high.
- `i_en`  in  1  one-cycle strobe marking a PS/2 clock falling edge.
- `i_dat`  in  1  PS/2 data line, synchronised to `clk`; sampled only when `i_en`=1.
- `o_data`  out  8  last accepted byte.
- `o_valid`  out  1  one-cycle pulse when `o_data` updates.
- `o_err`  out  1  one-cycle pulse on a rejected frame (parity, stop, or timeout).
- `o_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `o_history`  out  24  last three accepted bytes, newest in [7:0].

## Operation
- States: IDLE, DATA, PARITY, STOP. Transitions occur only on `i_en`, except timeout.
- IDLE: `i_en`&&`i_dat`=0 → DATA, bit counter=0. `i_en`&&`i_dat`=1 → stay IDLE, no error (spurious edge).
- DATA: each `i_en` shifts `i_dat` into shift register bit 7, shifting right (LSB first). On the 8th bit (counter=7) → PARITY.
- PARITY: `i_en` latches the parity bit → STOP.
- STOP: on `i_en`, the frame is good iff XOR(8 data bits, parity)=1 and `i_dat`=1.
  - Good frame: `o_data`←byte, `o_valid` pulses, `o_history`←{`o_history`[15:0], byte}.
  - Bad frame: `o_err` pulses; `o_data`/`o_history` are unchanged.
  - Either way → IDLE.
- `o_valid` and `o_err` are never high together.
- No break (F0) or extended (E0) prefix interpretation; every valid byte, prefixes included, enters history.
- Reset values: state IDLE; `o_data`=0x00; `o_valid`=0; `o_err`=0; `o_busy`=0; `o_history`=0x000000; shift register, bit counter and timeout counter 0.

## Timing
- `o_valid`/`o_err` are registered: high exactly in the cycle after the clock edge that sampled the stop-bit `i_en`; low the following cycle.
- `o_data` and `o_history` change in the same edge that raises `o_valid`.
- `o_busy` rises the cycle after the start-bit `i_en` and falls together with the `o_valid`/`o_err` pulse.
- Back-to-back frames: a start-bit `i_en` in the cycle right after the stop bit is accepted.
- Reset asserted mid-frame: immediately to reset values, no `o_err`; the partial frame is discarded.

## Configuration
- `PS2_FRAME_TIMEOUT_EN` defined: in non-IDLE states the timeout counter increments each cycle and clears on every `i_en`.
  - If it reaches `TIMEOUT_CYCLES`-1 with no `i_en`: → IDLE with an `o_err` pulse the next cycle.
  - If `i_en` arrives in the expiry cycle, `i_en` wins and no timeout occurs.
  - The counter is held at 0 in IDLE.
- Not defined: the counter and its logic are absent, and a partial frame waits indefinitely.

## Test plan
- Frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) → `o_data`=0x1C, one `o_valid` pulse, `o_history`=0x00001C, `o_err` never high.
- Frames 0xF0 then 0x1C back-to-back after 0x1C → `o_history`=0x1CF01C after the third; exactly three `o_valid` pulses.
- 0x1C with parity bit 1 → one `o_err` pulse, no `o_valid`, `o_data`/`o_history` unchanged.
- 0x1C with stop bit 0 → one `o_err` pulse, no `o_valid`; the next good 0x5A frame gives `o_data`=0x5A.
- With `PS2_FRAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: start + 4 data bits, then silence → `o_err` pulse after 16 idle cycles, `o_busy`=0; a following good 0x1C frame is accepted.
- `i_sclr` pulsed after 5 data bits → all outputs at reset values, no `o_err`; a subsequent full 0x29 frame gives `o_data`=0x29 and `o_history`=0x000029.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Validating receiver for 11-bit PS/2 device-to-host frames. Each frame is
//   a start bit, 8 data bits LSB first, odd parity and a stop bit. Each good
//   byte is published with a one-cycle strobe and shifted into a 24-bit
//   scan-code history. A frame with a parity or stop error raises a
//   one-cycle error strobe instead.
//
// Parameters
//   TIMEOUT_CYCLES  clk cycles allowed between PS/2 falling edges in a frame
//                   (must be >= 2; only used with PS2_FRAME_TIMEOUT_EN)
//
// Ports
//   clk        in   system clock, rising edge
//   i_sclr     in   asynchronous active-high reset
//   i_en       in   one-cycle strobe per PS/2 clock falling edge
//   i_dat      in   synchronised PS/2 data line, sampled when i_en=1
//   o_data     out  [7:0]  last accepted byte
//   o_valid    out  one-cycle pulse when o_data updates
//   o_err      out  one-cycle pulse on a rejected frame
//   o_busy     out  high while a frame is in progress
//   o_history  out  [23:0] last three accepted bytes, newest in [7:0]
//
// Configuration macro
//   PS2_FRAME_TIMEOUT_EN  when defined, a frame that stalls for
//                         TIMEOUT_CYCLES cycles without an edge is abandoned
//                         with an o_err pulse.

module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        i_sclr,
    input  logic        i_en,
    input  logic        i_dat,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_busy,
    output logic [23:0] o_history
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ps2_frame_rx: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  data_q, data_d;
    logic [23:0] hist_q, hist_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    // Odd parity over data + parity bit, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       par,
                                      input logic       stop);
        return ((^data) ^ par) & stop;
    endfunction

`ifdef PS2_FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        hist_d  = hist_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // A high bit on an edge while idle is a spurious edge.
                if (i_en && !i_dat) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                end
            end
            DATA: begin
                if (i_en) begin
                    // LSB arrives first, so shift in at the top.
                    shift_d = {i_dat, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (i_en) begin
                    par_d   = i_dat;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (i_en) begin
                    if (frame_ok(shift_q, par_q, i_dat)) begin
                        data_d  = shift_q;
                        hist_d  = {hist_q[15:0], shift_q};
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_FRAME_TIMEOUT_EN
        // The counter measures silence since the last edge; an edge in the
        // expiry cycle takes priority over the timeout.
        tmo_d = '0;
        if (state_q != IDLE && !i_en) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            hist_q  <= 24'h000000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            hist_q  <= hist_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef PS2_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_err     = err_q;
    assign o_busy    = (state_q != IDLE);
    assign o_history = hist_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
module tb_ps2_frame_rx;

    logic        clk;
    logic        i_sclr;
    logic        i_en;
    logic        i_dat;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_err;
    logic        o_busy;
    logic [23:0] o_history;

    int checks;
    int failures;
    int vcnt;
    int ecnt;
    int both_cnt;

    ps2_frame_rx #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .i_sclr    (i_sclr),
        .i_en      (i_en),
        .i_dat     (i_dat),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_err     (o_err),
        .o_busy    (o_busy),
        .o_history (o_history)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (o_valid) vcnt++;
        if (o_err) ecnt++;
        if (o_valid && o_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One PS/2 falling edge carrying bit b, then gap idle cycles.
    task automatic pulse(input logic b, input int gap);
        i_dat = b;
        i_en  = 1'b1;
        @(posedge clk);
        #1;
        i_en  = 1'b0;
        i_dat = 1'b1;
        step(gap);
    endtask

    // Full frame; returns in the cycle after the stop bit was sampled.
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop, input int gap);
        pulse(1'b0, gap);
        for (int i = 0; i < 8; i++) pulse(d[i], gap);
        pulse((~^d) ^ par_flip, gap);
        pulse(stop, 0);
    endtask

    initial begin
        int n;
        int e0;
        checks   = 0;
        failures = 0;
        vcnt     = 0;
        ecnt     = 0;
        both_cnt = 0;
        i_sclr   = 1'b1;
        i_en     = 1'b0;
        i_dat    = 1'b1;

        // Reset state
        step(3);
        chk("rst_data", {24'd0, o_data}, 32'h00);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_hist", {8'd0, o_history}, 32'h000000);
        i_sclr = 1'b0;
        step(2);

        // Spurious edge while idle: no frame starts
        pulse(1'b1, 1);
        chk("spurious_busy", {31'd0, o_busy}, 32'd0);

        // Good 0x1C frame
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        chk("f1_valid", {31'd0, o_valid}, 32'd1);
        chk("f1_data", {24'd0, o_data}, 32'h1C);
        chk("f1_hist", {8'd0, o_history}, 32'h00001C);
        chk("f1_busy", {31'd0, o_busy}, 32'd0);
        chk("f1_err", {31'd0, o_err}, 32'd0);

        // Back-to-back 0xF0 then 0x1C, start bit right after the stop bit
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        chk("f2_data", {24'd0, o_data}, 32'hF0);
        chk("f2_valid", {31'd0, o_valid}, 32'd1);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        chk("f3_hist", {8'd0, o_history}, 32'h1CF01C);
        step(1);
        chk("f3_valid_low", {31'd0, o_valid}, 32'd0);
        chk("b2b_vcnt", vcnt, 32'd3);
        chk("b2b_ecnt", ecnt, 32'd0);

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1, 1);
        chk("par_err", {31'd0, o_err}, 32'd1);
        chk("par_valid", {31'd0, o_valid}, 32'd0);
        chk("par_busy", {31'd0, o_busy}, 32'd0);
        step(1);
        chk("par_err_low", {31'd0, o_err}, 32'd0);
        chk("par_data", {24'd0, o_data}, 32'h1C);
        chk("par_hist", {8'd0, o_history}, 32'h1CF01C);
        chk("par_ecnt", ecnt, 32'd1);
        chk("par_vcnt", vcnt, 32'd3);

        // Stop-bit error, then good 0x5A
        send_frame(8'h1C, 1'b0, 1'b0, 1);
        chk("stop_err", {31'd0, o_err}, 32'd1);
        chk("stop_valid", {31'd0, o_valid}, 32'd0);
        step(1);
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        chk("f5a_valid", {31'd0, o_valid}, 32'd1);
        chk("f5a_data", {24'd0, o_data}, 32'h5A);
        chk("f5a_hist", {8'd0, o_history}, 32'hF01C5A);
        step(1);
        chk("f5a_ecnt", ecnt, 32'd2);
        chk("f5a_vcnt", vcnt, 32'd4);

        // Reset mid-frame after 5 data bits, then 0x29
        pulse(1'b0, 1);
        for (int i = 0; i < 5; i++) pulse(i[0], 1);
        chk("mid_busy", {31'd0, o_busy}, 32'd1);
        e0 = ecnt;
        i_sclr = 1'b1;
        #1;
        chk("mr_busy", {31'd0, o_busy}, 32'd0);
        chk("mr_data", {24'd0, o_data}, 32'h00);
        chk("mr_hist", {8'd0, o_history}, 32'h000000);
        step(2);
        i_sclr = 1'b0;
        step(2);
        chk("mr_noerr", ecnt, e0);
        send_frame(8'h29, 1'b0, 1'b1, 1);
        chk("f29_data", {24'd0, o_data}, 32'h29);
        chk("f29_hist", {8'd0, o_history}, 32'h000029);
        chk("f29_valid", {31'd0, o_valid}, 32'd1);
        step(1);

        // Stalled frame: start + 4 data bits, then silence
        pulse(1'b0, 1);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1);
        pulse(1'b0, 0);
        e0 = ecnt;
`ifdef PS2_FRAME_TIMEOUT_EN
        n = 0;
        while (!o_err && n < 40) begin
            step(1);
            n++;
        end
        chk("tmo_err", {31'd0, o_err}, 32'd1);
        chk("tmo_cycles", n, 32'd16);
        chk("tmo_busy", {31'd0, o_busy}, 32'd0);
        step(1);
        chk("tmo_err_low", {31'd0, o_err}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        chk("tmo_next_data", {24'd0, o_data}, 32'h1C);
        chk("tmo_next_valid", {31'd0, o_valid}, 32'd1);
        step(1);
`else
        n = 0;
        step(100);
        chk("wait_busy", {31'd0, o_busy}, 32'd1);
        chk("wait_noerr", ecnt, e0);
        i_sclr = 1'b1;
        step(1);
        i_sclr = 1'b0;
        step(1);
        chk("wait_rst_busy", {31'd0, o_busy}, 32'd0);
`endif

        chk("never_both", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
